// File: rtl/sub_64_bit_pkg.sv
// Shared width constant and word type for the registered signed subtractor.
package sub_64_bit_pkg;

  localparam int WIDTH_DEFAULT = 64;

  typedef logic signed [63:0] word_t;

endpackage

// File: rtl/sub_64_bit_full_adder.sv
// One-bit full adder cell, replicated into the subtractor's ripple chain.
module full_adder_1bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/sub_64_bit.sv
// Signed subtractor a - b built as a + ~b + 1 on a ripple chain, with a registered
// difference, signed-overflow flag and one-cycle valid.
module sub_64_bit
  import sub_64_bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] dif,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             ovf_comb;
  logic             unused_borrow;

  logic [WIDTH-1:0] dif_d, dif_q;
  logic             overflow_d, overflow_q;
  logic             out_valid_d, out_valid_q;

  // Carry-in of 1 together with inverted b forms the two's-complement negation.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_1bit u_fa (
      .x    (a[i]),
      .y    (~b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign unused_borrow = carry[WIDTH];

  assign ovf_comb = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    dif_d       = dif_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      dif_d       = sum;
      overflow_d  = ovf_comb;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dif_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      dif_q       <= dif_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dif       = dif_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sub_64_bit.sv
// Directed and random checks of the registered signed subtractor.
module tb_sub_64_bit;
  import sub_64_bit_pkg::*;

  localparam word_t MIN_W = 64'sh8000_0000_0000_0000;
  localparam word_t MAX_W = 64'sh7FFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] dif;
  logic        overflow;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  sub_64_bit #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .dif       (dif),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [65:0] obs;
    #1;
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== 66'd0) begin
      bad++;
      $display("[TB] FAIL reset_async: got %h want %h", obs, 66'd0);
    end
    repeat (2) @(negedge clk);
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== 66'd0) begin
      bad++;
      $display("[TB] FAIL reset_held: got %h want %h", obs, 66'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== 66'd0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got %h want %h", obs, 66'd0);
    end
  endtask

  task automatic test_zero();
    logic [65:0] obs;
    a = 64'd0; b = 64'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== {64'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL zero: got %h want %h", obs, {64'd0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_mixed_overflow();
    logic [65:0] obs;
    a = 64'h0000_0000_0000_C350; b = 64'h8000_0000_0000_8350; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== {64'h8000_0000_0000_4000, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL mixed_ovf: got %h want %h", obs, {64'h8000_0000_0000_4000, 1'b1, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    logic [65:0] obs;
    a = 64'h8000_0000_0000_0000; b = 64'd1; in_valid = 1'b1;
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1;
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL b2b_first: got %h want %h", obs, {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});
    end
    @(negedge clk);
    in_valid = 1'b0;
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL b2b_second: got %h want %h", obs, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1});
    end
  endtask

  task automatic test_hold();
    logic [65:0] obs;
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {dif, overflow, out_valid};
      total++;
      if (obs !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL hold_%0d: got %h want %h", i, obs, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_self_sub();
    logic [63:0] vals [4];
    logic [65:0] obs;
    vals[0] = MIN_W; vals[1] = MAX_W; vals[2] = 64'hFFFF_FFFF_FFFF_FFFF; vals[3] = 64'hA5A5_0000_5A5A_FFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = vals[i]; b = vals[i];
      @(negedge clk);
      obs = {dif, overflow, out_valid};
      total++;
      if (obs !== {64'd0, 1'b0, 1'b1}) begin
        bad++;
        $display("[TB] FAIL self_sub_%0d: got %h want %h", i, obs, {64'd0, 1'b0, 1'b1});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_zero_minus_min();
    logic [65:0] obs;
    a = 64'd0; b = MIN_W; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== {64'h8000_0000_0000_0000, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL zero_minus_min: got %h want %h", obs, {64'h8000_0000_0000_0000, 1'b1, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    logic [65:0] obs;
    a = 64'd5; b = 64'd3; in_valid = 1'b1;
    @(negedge clk);
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== {64'd2, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL pre_reset: got %h want %h", obs, {64'd2, 1'b0, 1'b1});
    end
    a = 64'd100; b = 64'd1;
    #2 rst_n = 1'b0;
    #1;
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== 66'd0) begin
      bad++;
      $display("[TB] FAIL async_reset: got %h want %h", obs, 66'd0);
    end
    @(negedge clk);
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== 66'd0) begin
      bad++;
      $display("[TB] FAIL reset_discard: got %h want %h", obs, 66'd0);
    end
    rst_n = 1'b1;
    a = 64'd7; b = 64'd10;
    @(negedge clk);
    in_valid = 1'b0;
    obs = {dif, overflow, out_valid};
    total++;
    if (obs !== {64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL first_capture: got %h want %h", obs, {64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1});
    end
  endtask

  task automatic test_random();
    logic [63:0]       ra, rb;
    logic signed [64:0] wide;
    logic [65:0]       exp_v, obs;
    int                rbad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 50 == 0) ? ra : {$urandom, $urandom};
      a = ra; b = rb;
      wide  = $signed({ra[63], ra}) - $signed({rb[63], rb});
      exp_v = {wide[63:0], wide[64] != wide[63], 1'b1};
      @(negedge clk);
      obs = {dif, overflow, out_valid};
      total++;
      if (obs !== exp_v) begin
        bad++;
        rbad++;
        if (rbad <= 20)
          $display("[TB] FAIL random_%0d: got %h want %h", i, obs, exp_v);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    test_reset();
    test_zero();
    test_mixed_overflow();
    test_back_to_back();
    test_hold();
    test_self_sub();
    test_zero_minus_min();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_64_bit.md
SUB_64_BIT -- requirements
Module: sub_64_bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand and result width in bits; the only required configuration is 64.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; port clk, input, 1 bit, rising-edge clock.
REQ-003 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-004 Port in_valid, input, 1 bit, SHALL qualify a and b for capture.
REQ-005 Port a, input, WIDTH bits, SHALL be the signed two's-complement minuend.
REQ-006 Port b, input, WIDTH bits, SHALL be the signed two's-complement subtrahend.
REQ-007 Port dif, output, WIDTH bits, SHALL be the registered signed difference a - b.
REQ-008 Port overflow, output, 1 bit, SHALL be the registered signed-overflow flag for the same operation.
REQ-009 Port out_valid, output, 1 bit, SHALL mark dif and overflow as holding a new result.

Function
REQ-010 The block SHALL compute dif = a + ~b + 1, using a carry-in of 1 into the LSB, truncated to WIDTH bits (two's-complement wrap-around).
REQ-011 The block SHALL set overflow = (a[MSB] != b[MSB]) AND (dif[MSB] != a[MSB]), where MSB is bit WIDTH-1 and dif is the unregistered result.
REQ-012 The block SHALL NOT expose the unsigned borrow or carry-out.
REQ-013 On a rising clk edge with in_valid=1, the block SHALL register dif and overflow from that cycle's a and b, and SHALL set out_valid=1; latency is exactly 1 cycle.
REQ-014 On a rising edge with in_valid=0, the block SHALL hold dif and overflow and SHALL clear out_valid to 0.
REQ-015 Back-to-back in_valid=1 SHALL give one result per cycle, with no stall and no backpressure.
REQ-016 a - a SHALL give dif=0 and overflow=0 for every a, including the most-negative value.
REQ-017 0 - MIN (0x8000_0000_0000_0000) SHALL give dif=MIN and overflow=1.

Reset
REQ-018 While rst_n=0, dif SHALL be 0, overflow SHALL be 0 and out_valid SHALL be 0, taking effect immediately without waiting for clk.
REQ-019 Reset asserted mid-operation SHALL discard any in-flight result.
REQ-020 The first capture SHALL occur on the first rising edge after rst_n rises with in_valid=1.

Structure
REQ-021 A shared package SHALL hold WIDTH_DEFAULT=64 and the word typedef (logic signed [63:0]).
REQ-022 The arithmetic SHALL be a combinational ripple chain of the sub-module full_adder_1bit (inputs x, y, cin; outputs s, cout), replicated WIDTH times by a generate loop.
REQ-023 Each full_adder_1bit y input SHALL receive the corresponding inverted b bit, and the chain carry-in SHALL be 1.
REQ-024 The output registers SHALL sit in the sub_64_bit top level only.

Verification
REQ-025 Reset: after rst_n=0, then in_valid=0 -> dif=0, overflow=0, out_valid=0.
REQ-026 Zero case: a=0, b=0, in_valid=1 -> next cycle dif=0, overflow=0, out_valid=1.
REQ-027 Mixed-sign overflow: a=0x0000_0000_0000_C350 (50000), b=0x8000_0000_0000_8350 -> dif=0x8000_0000_0000_4000, overflow=1.
REQ-028 Negative-overflow wrap and no-overflow case, run back-to-back:
- a=0x8000_0000_0000_0000, b=1 -> dif=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- a=-1, b=1 -> dif=0xFFFF_FFFF_FFFF_FFFE, overflow=0.
- Both results SHALL appear on consecutive cycles.
REQ-029 Hold: in_valid=0 for 3 cycles after a result -> dif and overflow unchanged, out_valid=0.
REQ-030 Async reset mid-stream: rst_n pulsed low between clk edges while in_valid=1 -> outputs go to 0 immediately, before the next edge.
REQ-031 Random check: 10,000 random a/b pairs SHALL match a reference model of a-b mod 2^64 and the REQ-011 overflow rule.
